pm_video_scaler: RTL and testbench



---
 rtl/pm_video_pkg.sv | 31 +++
 rtl/pm_video_scaler_if.sv | 24 ++
 rtl/pm_video_timing.sv | 61 ++++++
 rtl/pm_video_scaler.sv | 237 +++++++++++++++++++++++
 tb/tb_pm_video_scaler.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pm_video_pkg.sv
// Shared types, default 640x400@70 timing and helpers for the pm_video scaler.
package pm_video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 400;
    localparam int unsigned DEF_V_FP     = 12;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 35;
    localparam bit          DEF_HS_POL   = 1'b0;
    localparam bit          DEF_VS_POL   = 1'b1;

    // Top-left corner of the centred window; negative means it does not fit.
    function automatic int win_origin(input int active, input int src, input int scale);
        return (active - src * scale) / 2;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pm_video_scaler_if.sv
// Frame-buffer read port plus video output bundle of pm_video_scaler.
interface pm_video_scaler_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              hs;
    logic              vs;
    logic              de;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              frame_start;

    modport master (
        output fb_addr, hs, vs, de, r, g, b, frame_start,
        input  fb_data
    );

    modport slave (
        input  fb_addr, hs, vs, de, r, g, b, frame_start,
        output fb_data
    );
endinterface

// File: rtl/pm_video_timing.sv
// Stage-0 raster counters with combinational sync/DE/frame and line-end decodes.
module pm_video_timing
    import pm_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = DEF_HS_POL,
    parameter bit          VS_POL   = DEF_VS_POL,
    parameter int unsigned HW       = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          pclk,
    input  logic          reset_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          de_c,
    output logic          hs_c,
    output logic          vs_c,
    output logic          frame_start_c,
    output logic          line_end_c,
    output logic          frame_end_c
);
    localparam int unsigned HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
    localparam int unsigned HS_END = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
    localparam int unsigned VS_END = VS_BEG + V_SYNC;

    logic hs_act;
    logic vs_act;

    assign line_end_c    = (h_cnt == HW'(HT - 1));
    assign frame_end_c   = line_end_c && (v_cnt == VW'(VT - 1));
    assign de_c          = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign frame_start_c = (h_cnt == '0) && (v_cnt == '0);
    assign hs_act        = (h_cnt >= HW'(HS_BEG)) && (h_cnt < HW'(HS_END));
    assign vs_act        = (v_cnt >= VW'(VS_BEG)) && (v_cnt < VW'(VS_END));
    assign hs_c          = hs_act ? HS_POL : !HS_POL;
    assign vs_c          = vs_act ? VS_POL : !VS_POL;

    // Raster position: h wraps every line, v advances on each wrap.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end_c) begin
            h_cnt <= '0;
            v_cnt <= frame_end_c ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/pm_video_scaler.sv
// VGA timing plus integer-scaled 1bpp frame-buffer reader, two-clock aligned output pipeline.
// Optional LCD pixel-gap grid enabled by defining PM_VIDEO_GRID_EN.
module pm_video_scaler
    import pm_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter bit          HS_POL     = DEF_HS_POL,
    parameter bit          VS_POL     = DEF_VS_POL,
    parameter int unsigned SRC_W      = 96,
    parameter int unsigned SRC_H      = 64,
    parameter int unsigned H_SCALE    = 4,
    parameter int unsigned V_SCALE    = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter logic [23:0] ON_RGB     = 24'h202020,
    parameter logic [23:0] OFF_RGB    = 24'hB0C0A0,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic              pclk,
    input  logic              reset_n,
    pm_video_scaler_if.master vid
);
    localparam int unsigned HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW  = cnt_w(HT);
    localparam int unsigned VW  = cnt_w(VT);
    localparam int unsigned HSW = cnt_w(H_SCALE);
    localparam int unsigned VSW = cnt_w(V_SCALE);
    localparam int unsigned XW  = cnt_w(SRC_W + 1);
    localparam int unsigned YW  = cnt_w(SRC_H + 1);
    localparam int          X0  = win_origin(int'(H_ACTIVE), int'(SRC_W), int'(H_SCALE));
    localparam int          Y0  = win_origin(int'(V_ACTIVE), int'(SRC_H), int'(V_SCALE));
    localparam int          X1  = X0 + int'(SRC_W * H_SCALE);
    localparam int          Y1  = Y0 + int'(SRC_H * V_SCALE);

    if ((SRC_W * H_SCALE > H_ACTIVE) || (SRC_H * V_SCALE > V_ACTIVE)) begin : g_bad_window
        $error("pm_video_scaler: scaled source does not fit the active area");
    end
    if ((SRC_H % 8) != 0) begin : g_bad_height
        $error("pm_video_scaler: SRC_H must be a multiple of 8");
    end
`ifdef PM_VIDEO_GRID_EN
    if ((H_SCALE < 2) || (V_SCALE < 2)) begin : g_bad_grid
        $error("pm_video_scaler: pixel grid needs H_SCALE and V_SCALE of at least 2");
    end
`endif

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          de_c;
    logic          hs_c;
    logic          vs_c;
    logic          frame_start_c;
    logic          line_end_c;
    logic          frame_end_c;

    pm_video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .pclk          (pclk),
        .reset_n       (reset_n),
        .h_cnt         (h_cnt),
        .v_cnt         (v_cnt),
        .de_c          (de_c),
        .hs_c          (hs_c),
        .vs_c          (vs_c),
        .frame_start_c (frame_start_c),
        .line_end_c    (line_end_c),
        .frame_end_c   (frame_end_c)
    );

    logic in_win_h;
    logic in_win_v;
    logic in_win;

    assign in_win_h = (h_cnt >= HW'(X0)) && (h_cnt < HW'(X1));
    assign in_win_v = (v_cnt >= VW'(Y0)) && (v_cnt < VW'(Y1));
    assign in_win   = in_win_h && in_win_v;

    logic [HSW-1:0]    hsub;
    logic [VSW-1:0]    vsub;
    logic [XW-1:0]     src_x;
    logic [YW-1:0]     src_y;
    logic [ADDR_W-1:0] row_base;

    // Source coordinates tracked by replication sub-counters instead of dividers.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hsub     <= '0;
            vsub     <= '0;
            src_x    <= '0;
            src_y    <= '0;
            row_base <= '0;
        end else if (line_end_c) begin
            hsub  <= '0;
            src_x <= '0;
            if (frame_end_c) begin
                vsub     <= '0;
                src_y    <= '0;
                row_base <= '0;
            end else if (in_win_v) begin
                if (vsub == VSW'(V_SCALE - 1)) begin
                    vsub  <= '0;
                    src_y <= src_y + YW'(1);
                    if (src_y[2:0] == 3'd7) begin
                        row_base <= row_base + ADDR_W'(SRC_W);
                    end
                end else begin
                    vsub <= vsub + VSW'(1);
                end
            end
        end else if (in_win) begin
            if (hsub == HSW'(H_SCALE - 1)) begin
                hsub  <= '0;
                src_x <= src_x + XW'(1);
            end else begin
                hsub <= hsub + HSW'(1);
            end
        end
    end

    logic [ADDR_W-1:0] fb_addr_q;
    logic              de1;
    logic              win1;
    logic              hs1;
    logic              vs1;
    logic              fs1;
    logic [2:0]        bit1;

    // Stage 1: frame-buffer address issue; side-band follows the read latency.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            fb_addr_q <= '0;
            de1       <= 1'b0;
            win1      <= 1'b0;
            hs1       <= !HS_POL;
            vs1       <= !VS_POL;
            fs1       <= 1'b0;
            bit1      <= '0;
        end else begin
            if (in_win) begin
                fb_addr_q <= row_base + ADDR_W'(src_x);
            end
            de1  <= de_c;
            win1 <= in_win;
            hs1  <= hs_c;
            vs1  <= vs_c;
            fs1  <= frame_start_c;
            bit1 <= src_y[2:0];
        end
    end

`ifdef PM_VIDEO_GRID_EN
    logic grid1;

    // Last column or row of each scaled cell is dimmed to mimic the LCD gap.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            grid1 <= 1'b0;
        end else begin
            grid1 <= in_win && ((hsub == HSW'(H_SCALE - 1)) || (vsub == VSW'(V_SCALE - 1)));
        end
    end
`endif

    rgb_t pix_c;

    always_comb begin
        pix_c = '0;
        if (de1) begin
            if (!win1) begin
                pix_c = rgb_t'(BORDER_RGB);
            end else if (vid.fb_data[bit1]) begin
                pix_c = rgb_t'(ON_RGB);
            end else begin
                pix_c = rgb_t'(OFF_RGB);
            end
`ifdef PM_VIDEO_GRID_EN
            if (win1 && grid1) begin
                pix_c.r = pix_c.r >> 1;
                pix_c.g = pix_c.g >> 1;
                pix_c.b = pix_c.b >> 1;
            end
`endif
        end
    end

    rgb_t pix_q;
    logic hs_q;
    logic vs_q;
    logic de_q;
    logic fs_q;

    // Stage 2: every output registered together so all are cycle-aligned.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q <= '0;
            hs_q  <= !HS_POL;
            vs_q  <= !VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            pix_q <= pix_c;
            hs_q  <= hs1;
            vs_q  <= vs1;
            de_q  <= de1;
            fs_q  <= fs1 && de1;
        end
    end

    assign vid.fb_addr     = fb_addr_q;
    assign vid.hs          = hs_q;
    assign vid.vs          = vs_q;
    assign vid.de          = de_q;
    assign vid.frame_start = fs_q;
    assign vid.r           = pix_q.r;
    assign vid.g           = pix_q.g;
    assign vid.b           = pix_q.b;

endmodule

// File: tb/tb_pm_video_scaler.sv
// Self-checking bench for pm_video_scaler: raster model compared every pclk plus pinned literals.
// Vertical timing is shortened so a full frame and a mid-frame reset fit in a short run.
module tb_pm_video_scaler;
    localparam int HA = 640, HFP = 16, HSY = 96, HBP = 48, HT = 800;
    localparam int VA = 40, VFP = 4, VSY = 2, VBP = 2, VT = 48;
    localparam int SW = 96, SH = 16, HSC = 4, VSC = 2;
    localparam int X0 = 128, Y0 = 4;
    localparam logic [23:0] ON  = 24'h202020;
    localparam logic [23:0] OFF = 24'hB0C0A0;
    localparam logic [23:0] BRD = 24'h000000;
`ifdef PM_VIDEO_GRID_EN
    localparam logic [23:0] GRID_ON = 24'h101010;
`else
    localparam logic [23:0] GRID_ON = 24'h202020;
`endif

    logic pclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 pclk = ~pclk;

    logic [7:0] mem [0:1023];

    pm_video_scaler_if #(.ADDR_W(10)) vid();
    assign vid.fb_data = mem[vid.fb_addr];

    pm_video_scaler #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b1),
        .SRC_W(SW), .SRC_H(SH), .H_SCALE(HSC), .V_SCALE(VSC),
        .ADDR_W(10), .ON_RGB(ON), .OFF_RGB(OFF), .BORDER_RGB(BRD)
    ) dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .vid     (vid)
    );

    int checks = 0;
    int failures = 0;
    int t = 0;
    logic [9:0] exp_addr = 10'd0;

    // Number of clock edges since reset released.
    always @(posedge pclk or negedge reset_n) begin
        if (!reset_n) t <= 0;
        else          t <= t + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    function automatic int pix(input int h, input int v);
        return v * HT + h;
    endfunction

    function automatic bit in_win(input int h, input int v);
        return (h >= X0) && (h < X0 + SW * HSC) && (v >= Y0) && (v < Y0 + SH * VSC);
    endfunction

    function automatic int addr_of(input int p);
        int h, v, sx, sy;
        h = p % HT;
        v = (p / HT) % VT;
        if (!in_win(h, v)) return -1;
        sx = (h - X0) / HSC;
        sy = (v - Y0) / VSC;
        return (sy / 8) * SW + sx;
    endfunction

    // Expected {hs, vs, de, frame_start, rgb} for output pixel index p.
    function automatic logic [27:0] model(input int p);
        int h, v, sy;
        logic hs, vs, de, fs;
        logic [23:0] c;
        logic [7:0] byt;
        h  = p % HT;
        v  = (p / HT) % VT;
        de = (h < HA) && (v < VA);
        hs = (h >= HA + HFP && h < HA + HFP + HSY) ? 1'b0 : 1'b1;
        vs = (v >= VA + VFP && v < VA + VFP + VSY) ? 1'b1 : 1'b0;
        fs = (h == 0) && (v == 0);
        c  = 24'h0;
        if (de) begin
            if (in_win(h, v)) begin
                sy  = (v - Y0) / VSC;
                byt = mem[addr_of(p)];
                c   = byt[sy % 8] ? ON : OFF;
`ifdef PM_VIDEO_GRID_EN
                if (((h - X0) % HSC == HSC - 1) || ((v - Y0) % VSC == VSC - 1))
                    c = {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
`endif
            end else begin
                c = BRD;
            end
        end
        return {hs, vs, de, fs, c};
    endfunction

    always @(negedge pclk) begin
        logic [27:0] got, exp;
        logic [23:0] rgb;
        int p, pa, a;
        rgb = {vid.r, vid.g, vid.b};
        got = {vid.hs, vid.vs, vid.de, vid.frame_start, rgb};
        exp = (t < 2) ? {1'b1, 1'b0, 1'b0, 1'b0, 24'h0} : model(t - 2);
        if (t == 0) begin
            exp_addr = 10'd0;
        end else begin
            a = addr_of(t - 1);
            if (a >= 0) exp_addr = 10'(a);
        end
        if (failures < 50) begin
            chk("video_out", 32'(got), 32'(exp));
            chk("fb_addr", 32'(vid.fb_addr), 32'(exp_addr));
        end

        p  = t - 2;
        pa = t - 1;
        if (t == 2) begin
            chk("first_de", 32'(vid.de), 32'd1);
            chk("first_frame_start", 32'(vid.frame_start), 32'd1);
        end
        if (p == pix(639, 0))  chk("de_last_active", 32'(vid.de), 32'd1);
        if (p == pix(640, 0))  chk("de_after_active", 32'(vid.de), 32'd0);
        if (p == pix(0, 1))    chk("line_period_de", 32'(vid.de), 32'd1);
        if (p == pix(655, 0))  chk("hs_before", 32'(vid.hs), 32'd1);
        if (p == pix(656, 0))  chk("hs_first", 32'(vid.hs), 32'd0);
        if (p == pix(751, 0))  chk("hs_last", 32'(vid.hs), 32'd0);
        if (p == pix(752, 0))  chk("hs_after", 32'(vid.hs), 32'd1);
        if (p == pix(799, 43)) chk("vs_before", 32'(vid.vs), 32'd0);
        if (p == pix(0, 44))   chk("vs_first", 32'(vid.vs), 32'd1);
        if (p == pix(799, 45)) chk("vs_last", 32'(vid.vs), 32'd1);
        if (p == pix(0, 46))   chk("vs_after", 32'(vid.vs), 32'd0);
        if (p == HT * VT - 1)  chk("fs_end_frame", 32'(vid.frame_start), 32'd0);
        if (p == HT * VT)      chk("fs_second_frame", 32'(vid.frame_start), 32'd1);
        if (p == pix(127, 4)) begin
            chk("border_de", 32'(vid.de), 32'd1);
            chk("border_rgb", 32'(rgb), 32'(BRD));
        end
        if (p == pix(128, 4))  chk("row0_on", 32'(rgb), 32'(ON));
        if (p == pix(131, 4))  chk("grid_cell_end", 32'(rgb), 32'(GRID_ON));
        if (p == pix(128, 6))  chk("row1_off", 32'(rgb), 32'(OFF));
        if (p == pix(640, 4))  chk("blank_rgb", 32'(rgb), 32'd0);
        if (pa == pix(128, 4)) chk("addr_x128", 32'(vid.fb_addr), 32'd0);
        if (pa == pix(131, 4)) chk("addr_x131", 32'(vid.fb_addr), 32'd0);
        if (pa == pix(132, 4)) chk("addr_x132", 32'(vid.fb_addr), 32'd1);
        if (pa == pix(128, 20)) chk("addr_row8", 32'(vid.fb_addr), 32'd96);
        if (pa == pix(511, 35)) chk("addr_last", 32'(vid.fb_addr), 32'd191);
        if (pa == pix(0, 36))   chk("addr_hold", 32'(vid.fb_addr), 32'd191);
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hs"}, 32'(vid.hs), 32'd1);
        chk({tag, "_vs"}, 32'(vid.vs), 32'd0);
        chk({tag, "_de"}, 32'(vid.de), 32'd0);
        chk({tag, "_fs"}, 32'(vid.frame_start), 32'd0);
        chk({tag, "_rgb"}, 32'({vid.r, vid.g, vid.b}), 32'd0);
        chk({tag, "_addr"}, 32'(vid.fb_addr), 32'd0);
    endtask

    initial begin
        int target;
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 73 + 11) ^ (i >> 3));
        mem[0] = 8'h01;

        reset_n = 1'b0;
        repeat (4) @(negedge pclk);
        #1 chk_reset_vals("in_reset");
        @(negedge pclk);
        reset_n = 1'b1;

        // Run into the second frame, then pulse reset mid-line.
        target = 2 + HT * VT + 10 * HT + 300;
        for (int i = 0; i < 60000 && t < target; i++) @(negedge pclk);
        chk("reach_mid_frame", 32'(t), 32'(target));
        chk("mid_frame_de", 32'(vid.de), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("mid_reset");
        repeat (3) @(negedge pclk);
        reset_n = 1'b1;

        for (int i = 0; i < 4000; i++) @(negedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
